// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the neural-net datapath: Q-format defaults,
// dense-layer FSM states and the floor-then-clamp narrowing helper.
package nn_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int FRAC_W_DEF = 8;
   localparam int SAT_W      = 96;

   typedef enum logic [2:0] {IDLE, WAIT_IN, MAC, DRAIN, OUT, FIN} state_e;

   // Arithmetic shift floors toward -inf; the caller keeps the low data_w bits.
   function automatic logic signed [SAT_W-1:0] sat_shift(
      input logic signed [SAT_W-1:0] acc,
      input int                      frac_w,
      input int                      data_w
   );
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] sh;
      one    = '0;
      one[0] = 1'b1;
      hi     = (one <<< (data_w - 1)) - one;
      lo     = -(one <<< (data_w - 1));
      sh     = acc >>> frac_w;
      if (sh > hi) return hi;
      if (sh < lo) return lo;
      return sh;
   endfunction

endpackage

// File: rtl/dense_layer_engine_if.sv
// Control, activation-in, weight-SRAM and result-out signals of the dense layer engine.
interface dense_layer_engine_if
   import nn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int W_AW   = 7
);
   logic              start;
   logic              acc_keep;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [W_AW-1:0]   w_addr;
   logic              w_en;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, acc_keep, in_data, in_valid, w_rdata, out_ready,
      input  in_ready, w_addr, w_en, out_data, out_valid, busy, done
   );

   modport slave (
      input  start, acc_keep, in_data, in_valid, w_rdata, out_ready,
      output in_ready, w_addr, w_en, out_data, out_valid, busy, done
   );

endinterface

// File: rtl/dense_layer_engine_acc.sv
// One ACC_W accumulator per output neuron with bulk clear, add-at-index and a
// combinational read port; contents survive between runs unless cleared or reset.
module acc_bank #(
   parameter int N_OUT = 10,
   parameter int ACC_W = 37,
   parameter int IDX_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr_i,
   input  logic                    add_vld_i,
   input  logic [IDX_W-1:0]        add_idx_i,
   input  logic signed [ACC_W-1:0] add_val_i,
   input  logic [IDX_W-1:0]        rd_idx_i,
   output logic signed [ACC_W-1:0] rd_val_o
);

   logic signed [ACC_W-1:0] acc_q [N_OUT];
   logic signed [ACC_W-1:0] acc_d [N_OUT];

   always_comb begin
      for (int k = 0; k < N_OUT; k++) begin
         acc_d[k] = acc_q[k];
         if (clr_i) begin
            acc_d[k] = '0;
         end else if (add_vld_i && (add_idx_i == IDX_W'(k))) begin
            acc_d[k] = acc_q[k] + add_val_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];
      end
   end

   assign rd_val_o = acc_q[rd_idx_i];

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer: one input per WAIT_IN, N_OUT weight fetches with a one-cycle
// product pipeline, then the saturated accumulators stream out under valid/ready.
module dense_layer_engine
   import nn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int N_IN   = 10,
   parameter int N_OUT  = 10,
   parameter int ACC_W  = 2*DATA_W + $clog2(N_IN) + 1,
   parameter int W_AW   = $clog2(N_IN*N_OUT)
) (
   input  logic                clk,
   input  logic                reset,
   dense_layer_engine_if.slave bus
);

   localparam int IN_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   state_e                   state_q, state_d;
   logic [IN_W-1:0]          i_q, i_d;
   logic [IDX_W-1:0]         j_q, j_d;
   logic [IDX_W-1:0]         jdly_q;
   logic [IDX_W-1:0]         out_idx_q, out_idx_d;
   logic [W_AW-1:0]          addr_q, addr_d;
   logic signed [DATA_W-1:0] x_q, x_d;
   logic                     mac_vld_q;
   logic                     clr_acc;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]  add_val;
   logic signed [ACC_W-1:0]  rd_acc;
   logic signed [SAT_W-1:0]  sat_res;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         i_q       <= '0;
         j_q       <= '0;
         jdly_q    <= '0;
         out_idx_q <= '0;
         addr_q    <= '0;
         x_q       <= '0;
         mac_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         jdly_q    <= j_q;
         out_idx_q <= out_idx_d;
         addr_q    <= addr_d;
         x_q       <= x_d;
         mac_vld_q <= (state_q == MAC);
      end
   end

   // Weights are laid out row-major, so the address simply counts up across the run.
   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      j_d           = j_q;
      out_idx_d     = out_idx_q;
      addr_d        = addr_q;
      x_d           = x_q;
      clr_acc       = 1'b0;
      bus.in_ready  = (state_q == WAIT_IN);
      bus.w_en      = (state_q == MAC);
      bus.w_addr    = (state_q == MAC) ? addr_q : '0;
      bus.out_valid = (state_q == OUT);
      bus.out_data  = (state_q == OUT) ? sat_res[DATA_W-1:0] : '0;
      bus.busy      = (state_q != IDLE);
      bus.done      = (state_q == FIN);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               clr_acc = !bus.acc_keep;
               i_d     = '0;
               addr_d  = '0;
               state_d = WAIT_IN;
            end
         end
         WAIT_IN: begin
            if (bus.in_valid) begin
               x_d     = bus.in_data;
               j_d     = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            addr_d = addr_q + 1'b1;
            j_d    = j_q + 1'b1;
            if (j_q == IDX_W'(N_OUT - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (i_q == IN_W'(N_IN - 1)) begin
               out_idx_d = '0;
               state_d   = OUT;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = WAIT_IN;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               if (out_idx_q == IDX_W'(N_OUT - 1)) state_d = FIN;
               else out_idx_d = out_idx_q + 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign prod    = (2*DATA_W)'(x_q) * (2*DATA_W)'($signed(bus.w_rdata));
   assign add_val = ACC_W'(prod);
   assign sat_res = sat_shift(SAT_W'(rd_acc), FRAC_W, DATA_W);

   acc_bank #(
      .N_OUT (N_OUT),
      .ACC_W (ACC_W),
      .IDX_W (IDX_W)
   ) u_acc (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (clr_acc),
      .add_vld_i (mac_vld_q),
      .add_idx_i (jdly_q),
      .add_val_i (add_val),
      .rd_idx_i  (out_idx_q),
      .rd_val_o  (rd_acc)
   );

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed and randomised runs of a 2x2 dense_layer_engine against a sum-of-products model.
module tb_dense_layer_engine;

   localparam int NI = 2;
   localparam int NO = 2;
   localparam int DW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dense_layer_engine_if #(.DATA_W(DW), .W_AW(2)) bus ();

   dense_layer_engine #(
      .DATA_W (DW),
      .FRAC_W (8),
      .N_IN   (NI),
      .N_OUT  (NO),
      .ACC_W  (37),
      .W_AW   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] wmem [4];
   logic [15:0] xv [2];
   logic [15:0] got [2];
   longint      m_acc [2];
   logic [1:0]  addr_log [$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          errors = 0;
   int          checks = 0;

   // External weight SRAM: data one cycle after the enable.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.w_en) bus.w_rdata <= wmem[bus.w_addr];
   end

   always @(negedge clk) begin
      if (bus.w_en) addr_log.push_back(bus.w_addr);
      if (bus.done) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   function automatic longint sx(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [15:0] sat_ref(input longint a);
      longint s;
      s = a >>> 8;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      return s[15:0];
   endfunction

   task automatic wait_in_ready(input string tag);
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk(tag, 0, 1);
   endtask

   task automatic run(input bit keep, input int gap, input int stall, input bit spur, input bit timing);
      int n;
      int t0;
      int d0;
      if (!keep) m_acc = '{0, 0};
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NO; j++)
            m_acc[j] += sx(xv[i]) * sx(wmem[i*NO + j]);
      addr_log.delete();
      d0 = done_cnt;
      t0 = 0;
      bus.start    = 1'b1;
      bus.acc_keep = keep;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.acc_keep = 1'b0;
      chk("busy_after_start", bus.busy, 1);
      for (int i = 0; i < NI; i++) begin
         if (i > 0 && gap > 0) begin
            bus.in_valid = 1'b0;
            wait_in_ready("in_ready_timeout");
            repeat (gap) @(negedge clk);
            chk("in_ready_held", bus.in_ready, 1);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = xv[i];
         wait_in_ready("in_ready_timeout");
         if (i == 0) t0 = cyc;
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_data  = 16'($urandom);
         if (i == 0 && spur) begin
            bus.start    = 1'b1;
            bus.acc_keep = 1'b1;
            @(negedge clk);
            bus.start    = 1'b0;
            bus.acc_keep = 1'b0;
         end
      end
      for (int k = 0; k < NO; k++) begin
         n = 0;
         while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) chk("out_valid_timeout", 0, 1);
         if (k == 0 && timing) chk("latency", cyc - t0, 8);
         if (k == 0 && spur) begin
            bus.out_ready = 1'b0;
            bus.start     = 1'b1;
            @(negedge clk);
            bus.start     = 1'b0;
            chk("spur_out_valid", bus.out_valid, 1);
         end
         for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, sat_ref(m_acc[k]));
         end
         bus.out_ready = 1'b1;
         got[k] = bus.out_data;
         chk("out_data", got[k], sat_ref(m_acc[k]));
         chk("no_early_done", done_cnt, d0);
         @(negedge clk);
      end
      chk("done_pulse", bus.done, 1);
      @(negedge clk);
      chk("done_once", done_cnt, d0 + 1);
      chk("idle_after_done", bus.busy, 0);
      chk("w_en_count", addr_log.size(), NI*NO);
      if (addr_log.size() == NI*NO)
         for (int a = 0; a < NI*NO; a++) chk("w_addr_seq", addr_log[a], a);
   endtask

   task automatic load_run1();
      xv   = '{16'h0100, 16'h0200};
      wmem = '{16'h0080, 16'hFF00, 16'h0100, 16'h0040};
   endtask

   initial begin
      int d0;
      bus.start     = 1'b0;
      bus.acc_keep  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      m_acc         = '{0, 0};
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_w_en", bus.w_en, 0);
      chk("rst_w_addr", bus.w_addr, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      reset = 1'b1;
      @(negedge clk);

      load_run1();
      run(0, 0, 0, 0, 1);
      chk("run1_out0", got[0], 16'h0280);
      chk("run1_out1", got[1], 16'hFF80);
      run(1, 0, 0, 0, 1);
      chk("chain_out0", got[0], 16'h0500);
      chk("chain_out1", got[1], 16'hFF00);
      run(0, 0, 0, 0, 1);
      chk("clear_out0", got[0], 16'h0280);
      chk("clear_out1", got[1], 16'hFF80);

      xv   = '{16'h7FFF, 16'h7FFF};
      wmem = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
      run(0, 0, 0, 0, 0);
      chk("sat_pos", got[0], 16'h7FFF);
      xv = '{16'h8000, 16'h8000};
      run(0, 0, 0, 0, 0);
      chk("sat_neg", got[0], 16'h8000);
      xv   = '{16'hFFFF, 16'h0000};
      wmem = '{16'h0080, 16'h0000, 16'h0000, 16'h0000};
      run(0, 0, 0, 0, 0);
      chk("floor_neg", got[0], 16'hFFFF);
      chk("floor_zero", got[1], 16'h0000);

      load_run1();
      run(0, 3, 5, 0, 0);
      chk("bp_out0", got[0], 16'h0280);
      chk("bp_out1", got[1], 16'hFF80);

      // Abort during the MAC of the second input, then chain onto whatever survived.
      d0 = done_cnt;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = xv[0];
      wait_in_ready("abort_in0_timeout");
      @(negedge clk);
      bus.in_data = xv[1];
      @(negedge clk);
      wait_in_ready("abort_in1_timeout");
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_w_en", bus.w_en, 0);
      chk("abort_out_data", bus.out_data, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt, d0);
      m_acc = '{0, 0};
      run(1, 0, 0, 0, 1);
      chk("abort_out0", got[0], 16'h0280);
      chk("abort_out1", got[1], 16'hFF80);

      run(0, 0, 0, 1, 1);
      chk("spur_out0", got[0], 16'h0280);
      chk("spur_out1", got[1], 16'hFF80);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < NI; i++)
            xv[i] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800) - 16'h0400);
         for (int a = 0; a < NI*NO; a++)
            wmem[a] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800) - 16'h0400);
         run((r == 0) ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
